// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Read returns are steered back to their owner using a one-cycle {valid, owner} tag.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   i_pc_addr,
  input  logic            i_pc_rd,
  output logic            o_pc_waitrequest,
  output logic [DW-1:0]   o_pc_rddata,
  output logic            o_pc_rddata_valid,
  input  logic [AW-1:0]   i_ldst_addr,
  input  logic            i_ldst_rd,
  input  logic            i_ldst_wr,
  input  logic [DW-1:0]   i_ldst_wrdata,
  input  logic [DW/8-1:0] i_ldst_byte_en,
  output logic            o_ldst_waitrequest,
  output logic [DW-1:0]   o_ldst_rddata,
  output logic            o_ldst_rddata_valid,
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic [DW-1:0]   o_mem_wrdata,
  output logic [DW/8-1:0] o_mem_byte_en,
  input  logic [DW-1:0]   i_mem_rddata
);

  typedef enum logic {
    GRANT_PC   = 1'b0,
    GRANT_LDST = 1'b1
  } grant_e;

  grant_e last_grant;
  grant_e next_grant;
  logic   pc_req;
  logic   ldst_req;
  logic   grant_pc;
  logic   grant_ldst;
  logic   tag_valid;
  logic   tag_owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_LDST;
    end else begin
      last_grant <= next_grant;
    end
  end

  // Nothing is granted while reset is high, so both ports see a stall.
  always_comb begin
    pc_req     = i_pc_rd;
    ldst_req   = i_ldst_rd | i_ldst_wr;
    grant_pc   = 1'b0;
    grant_ldst = 1'b0;
    next_grant = last_grant;
    if (!reset) begin
      if (pc_req && (!ldst_req || last_grant == GRANT_LDST)) begin
        grant_pc = 1'b1;
      end else if (ldst_req) begin
        grant_ldst = 1'b1;
      end
    end
    if (grant_pc) begin
      next_grant = GRANT_PC;
    end else if (grant_ldst) begin
      next_grant = GRANT_LDST;
    end
  end

  // A simultaneous read and write from load/store is issued as a write only.
  always_comb begin
    o_mem_addr         = i_ldst_addr;
    o_mem_wrdata       = i_ldst_wrdata;
    o_mem_byte_en      = i_ldst_byte_en;
    o_mem_rd           = 1'b0;
    o_mem_wr           = 1'b0;
    o_pc_waitrequest   = reset | (pc_req & ~grant_pc);
    o_ldst_waitrequest = reset | (ldst_req & ~grant_ldst);
    if (grant_pc) begin
      o_mem_addr    = i_pc_addr;
      o_mem_byte_en = '1;
      o_mem_rd      = 1'b1;
    end else if (grant_ldst) begin
      o_mem_wr = i_ldst_wr;
      o_mem_rd = i_ldst_rd & ~i_ldst_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= 1'b0;
      tag_owner <= 1'b0;
    end else begin
      tag_valid <= o_mem_rd;
      tag_owner <= grant_ldst;
    end
  end

  assign o_pc_rddata         = i_mem_rddata;
  assign o_ldst_rddata       = i_mem_rddata;
  assign o_pc_rddata_valid   = tag_valid & ~tag_owner;
  assign o_ldst_rddata_valid = tag_valid & tag_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory requests and read returns,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wrdata;
  } mem_txn_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } ret_t;

  logic        clk;
  logic        reset;
  logic [31:0] i_pc_addr;
  logic        i_pc_rd;
  logic        o_pc_waitrequest;
  logic [31:0] o_pc_rddata;
  logic        o_pc_rddata_valid;
  logic [31:0] i_ldst_addr;
  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [31:0] i_ldst_wrdata;
  logic [3:0]  i_ldst_byte_en;
  logic        o_ldst_waitrequest;
  logic [31:0] o_ldst_rddata;
  logic        o_ldst_rddata_valid;
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [31:0] o_mem_wrdata;
  logic [3:0]  o_mem_byte_en;
  logic [31:0] i_mem_rddata;

  mem_txn_t mem_q[$];
  ret_t     ret_q[$];
  int       tests_run;
  int       tests_failed;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_pc_addr           (i_pc_addr),
    .i_pc_rd             (i_pc_rd),
    .o_pc_waitrequest    (o_pc_waitrequest),
    .o_pc_rddata         (o_pc_rddata),
    .o_pc_rddata_valid   (o_pc_rddata_valid),
    .i_ldst_addr         (i_ldst_addr),
    .i_ldst_rd           (i_ldst_rd),
    .i_ldst_wr           (i_ldst_wr),
    .i_ldst_wrdata       (i_ldst_wrdata),
    .i_ldst_byte_en      (i_ldst_byte_en),
    .o_ldst_waitrequest  (o_ldst_waitrequest),
    .o_ldst_rddata       (o_ldst_rddata),
    .o_ldst_rddata_valid (o_ldst_rddata_valid),
    .o_mem_addr          (o_mem_addr),
    .o_mem_rd            (o_mem_rd),
    .o_mem_wr            (o_mem_wr),
    .o_mem_wrdata        (o_mem_wrdata),
    .o_mem_byte_en       (o_mem_byte_en),
    .i_mem_rddata        (i_mem_rddata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: data is a fixed function of the address, returned one cycle later.
  always @(posedge clk) begin
    i_mem_rddata <= o_mem_addr ^ KEY;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkReturn(input logic owner, input logic [31:0] data);
    ret_t e;
    if (ret_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL unexpected_rddata_valid: got owner %0d with empty scoreboard expected none", owner);
    end else begin
      e = ret_q.pop_front();
      checkOutput("ret_owner", {31'b0, owner}, {31'b0, e.owner});
      checkOutput("ret_data", data, e.data);
    end
  endtask

  // Monitor: compares every memory request and every read return against the scoreboard.
  always @(negedge clk) begin
    mem_txn_t e;
    if (o_mem_rd || o_mem_wr) begin
      if (mem_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_mem_req: got addr 0x%0h rd %0d wr %0d expected none",
                 o_mem_addr, o_mem_rd, o_mem_wr);
      end else begin
        e = mem_q.pop_front();
        checkOutput("mem_addr", o_mem_addr, e.addr);
        checkOutput("mem_rd", {31'b0, o_mem_rd}, {31'b0, e.rd});
        checkOutput("mem_wr", {31'b0, o_mem_wr}, {31'b0, e.wr});
        checkOutput("mem_byte_en", {28'b0, o_mem_byte_en}, {28'b0, e.be});
        if (e.wr) checkOutput("mem_wrdata", o_mem_wrdata, e.wrdata);
      end
    end
    if (o_pc_rddata_valid && o_ldst_rddata_valid) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL both_valid: got both rddata_valid high expected at most one");
    end else if (o_pc_rddata_valid) begin
      checkReturn(1'b0, o_pc_rddata);
    end else if (o_ldst_rddata_valid) begin
      checkReturn(1'b1, o_ldst_rddata);
    end
  end

  // grant: 0 = nobody, 1 = pc, 2 = ldst (hand-computed per vector).
  task automatic applyStimulus(input logic pc_rd, input logic [31:0] pc_addr,
                               input logic ldst_rd, input logic ldst_wr, input logic [31:0] ldst_addr,
                               input logic [31:0] wrdata, input logic [3:0] be,
                               input int grant, input logic exp_pc_wait, input logic exp_ldst_wait);
    i_pc_rd        = pc_rd;
    i_pc_addr      = pc_addr;
    i_ldst_rd      = ldst_rd;
    i_ldst_wr      = ldst_wr;
    i_ldst_addr    = ldst_addr;
    i_ldst_wrdata  = wrdata;
    i_ldst_byte_en = be;
    if (grant == 1) begin
      mem_q.push_back('{addr: pc_addr, rd: 1'b1, wr: 1'b0, be: 4'hF, wrdata: 32'h0});
      ret_q.push_back('{owner: 1'b0, data: pc_addr ^ KEY});
    end else if (grant == 2) begin
      mem_q.push_back('{addr: ldst_addr, rd: ldst_rd & ~ldst_wr, wr: ldst_wr, be: be, wrdata: wrdata});
      if (ldst_rd && !ldst_wr) ret_q.push_back('{owner: 1'b1, data: ldst_addr ^ KEY});
    end
    @(negedge clk);
    checkOutput("pc_waitrequest", {31'b0, o_pc_waitrequest}, {31'b0, exp_pc_wait});
    checkOutput("ldst_waitrequest", {31'b0, o_ldst_waitrequest}, {31'b0, exp_ldst_wait});
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic checkInReset();
    checkOutput("rst_pc_wait", {31'b0, o_pc_waitrequest}, 32'd1);
    checkOutput("rst_ldst_wait", {31'b0, o_ldst_waitrequest}, 32'd1);
    checkOutput("rst_mem_rd", {31'b0, o_mem_rd}, 32'd0);
    checkOutput("rst_mem_wr", {31'b0, o_mem_wr}, 32'd0);
    checkOutput("rst_pc_valid", {31'b0, o_pc_rddata_valid}, 32'd0);
    checkOutput("rst_ldst_valid", {31'b0, o_ldst_rddata_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset          = 1'b1;
    i_pc_rd        = 1'b1;
    i_pc_addr      = 32'h10;
    i_ldst_rd      = 1'b1;
    i_ldst_wr      = 1'b0;
    i_ldst_addr    = 32'h20;
    i_ldst_wrdata  = 32'h0;
    i_ldst_byte_en = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkInReset();
    i_pc_rd   = 1'b0;
    i_ldst_rd = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First tie after reset goes to pc; ldst follows next cycle.
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 2, 1'b0, 1'b0);
    idleCycle();

    // Continuous contention: strict alternation, loser holds its address.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        applyStimulus(1'b1, 32'h300 + 32'(((i + 1) / 2) * 4), 1'b1, 1'b0, 32'h400 + 32'((i / 2) * 4),
                      32'h0, 4'hF, 1, 1'b0, 1'b1);
      else
        applyStimulus(1'b1, 32'h300 + 32'(((i + 1) / 2) * 4), 1'b1, 1'b0, 32'h400 + 32'((i / 2) * 4),
                      32'h0, 4'hF, 2, 1'b1, 1'b0);
    end
    idleCycle();

    // Store with partial byte lanes, then read+write collapsing to a write.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, 2, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h12345678, 4'b1111, 2, 1'b0, 1'b0);
    idleCycle();

    // Back-to-back pc fetch stream.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 1'b0, 1'b0);

    // Alternating owners without contention, then ties following each kind of last grant.
    applyStimulus(1'b0, 32'h0,   1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h504, 1'b0, 1'b0, 32'h0,   32'h0, 4'hF, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0,   1'b1, 1'b0, 32'h508, 32'h0, 4'hF, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h50C, 1'b1, 1'b0, 32'h510, 32'h0, 4'hF, 1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0,   1'b1, 1'b0, 32'h510, 32'h0, 4'hF, 2, 1'b0, 0);
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0,   32'h0, 4'hF, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h604, 1'b1, 1'b0, 32'h608, 32'h0, 4'hF, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h604, 1'b0, 1'b0, 32'h0,   32'h0, 4'hF, 1, 1'b0, 1'b0);
    idleCycle();

    // pc read granted, then reset lands before its return cycle: the return is dropped.
    i_pc_rd   = 1'b1;
    i_pc_addr = 32'h700;
    mem_q.push_back('{addr: 32'h700, rd: 1'b1, wr: 1'b0, be: 4'hF, wrdata: 32'h0});
    @(negedge clk);
    checkOutput("pre_rst_pc_wait", {31'b0, o_pc_waitrequest}, 32'd0);
    #1;
    reset   = 1'b1;
    i_pc_rd = 1'b0;
    @(negedge clk);
    checkInReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_pc_valid", {31'b0, o_pc_rddata_valid}, 32'd0);
    checkOutput("post_rst_ldst_valid", {31'b0, o_ldst_rddata_valid}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h800, 1'b1, 1'b0, 32'h900, 32'h0, 4'hF, 1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0,   1'b1, 1'b0, 32'h900, 32'h0, 4'hF, 2, 1'b0, 1'b0);
    idleCycle();
    idleCycle();

    checkOutput("mem_q_drained", 32'(mem_q.size()), 32'd0);
    checkOutput("ret_q_drained", 32'(ret_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
